// File: rtl/vend_pkg.sv
// Shared state encoding and coin decoding for the vending controller.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_RECEIVE_MONEY,
    ST_COMPARE,
    ST_PROCESS,
    ST_RETURN_CHANGE
  } vend_state_e;

  localparam logic [2:0] COIN_1  = 3'd1;
  localparam logic [2:0] COIN_2  = 3'd2;
  localparam logic [2:0] COIN_5  = 3'd3;
  localparam logic [2:0] COIN_10 = 3'd4;
  localparam logic [2:0] COIN_20 = 3'd5;

  localparam int COIN_VAL_W = 5;

  // A zero return marks an unrecognised coin code.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_1:  return 5'd1;
      COIN_2:  return 5'd2;
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      COIN_20: return 5'd20;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters: decrement on vend, saturating restock, empty flags.
module vend_stock #(
  parameter int N_ITEMS    = 4,
  parameter int ITEM_W     = 2,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dec_en,
  input  logic [ITEM_W-1:0]  dec_item,
  input  logic               restock_en,
  input  logic [ITEM_W-1:0]  restock_item,
  input  logic [STOCK_W-1:0] restock_qty,
  output logic [N_ITEMS-1:0] empty
);

  logic [STOCK_W-1:0] stock_q [N_ITEMS];

  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (dec_en && dec_item == ITEM_W'(i) && stock_q[i] != '0)
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
        else if (restock_en && restock_item == ITEM_W'(i))
          stock_q[i] <= sat_add(stock_q[i], restock_qty);
      end
    end
  end

  always_comb begin
    empty = '0;
    for (int i = 0; i < N_ITEMS; i++) empty[i] = (stock_q[i] == '0);
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending session controller: item select, coin credit, vend, change return.
//
// state            | meaning
// ST_IDLE          | no session; restock allowed
// ST_SELECT        | waiting for an item selection or cancel
// ST_RECEIVE_MONEY | accepting coins, idle timeout running
// ST_COMPARE       | credit vs price decision
// ST_PROCESS       | vend: deduct price, take one from stock
// ST_RETURN_CHANGE | hand back residual credit, end session
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int ITEM_W     = $clog2(N_ITEMS),
  parameter int SUM_W      = 8,
  parameter int STOCK_W    = 4,
  parameter int MAX_MONEY  = 31,
  parameter int INIT_STOCK = 3,
  parameter int TIMEOUT    = 64,
  parameter logic [N_ITEMS*SUM_W-1:0] PRICE_TABLE = {8'd20, 8'd15, 8'd10, 8'd5}
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               cancel,
  input  logic               done_money,
  input  logic               continue_buy,
  input  logic               coin_valid,
  input  logic [2:0]         money,
  input  logic               item_valid,
  input  logic [ITEM_W-1:0]  item_in,
  input  logic               restock_en,
  input  logic [ITEM_W-1:0]  restock_item,
  input  logic [STOCK_W-1:0] restock_qty,
  output logic               done,
  output logic               end_trans,
  output logic [SUM_W-1:0]   sum_money,
  output logic [SUM_W-1:0]   price,
  output logic [ITEM_W-1:0]  item_select,
  output logic [SUM_W-1:0]   change,
  output logic               out_stock,
  output logic               coin_reject,
  output logic               insufficient
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  vend_state_e state_q, state_d;

  logic [SUM_W-1:0]      credit_q, credit_d, price_d, change_d, sel_price;
  logic [ITEM_W-1:0]     item_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  done_d, end_d, out_stock_d, reject_d, insuf_d;
  logic                  stock_dec, stock_restock;
  logic [N_ITEMS-1:0]    empty;
  logic [COIN_VAL_W-1:0] coin_val;
  logic [SUM_W:0]        credit_sum;
  logic                  coin_ok, coin_over, can_buy, sel_empty;

  assign coin_val   = coin_value(money);
  assign coin_ok    = (coin_val != '0);
  assign credit_sum = {1'b0, credit_q} + (SUM_W+1)'(coin_val);
  assign coin_over  = credit_sum > (SUM_W+1)'(MAX_MONEY);
  assign can_buy    = (credit_q >= price);
  assign sel_empty  = empty[item_in];
  assign sel_price  = PRICE_TABLE[SUM_W*int'(item_in) +: SUM_W];
  assign sum_money  = credit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start) state_d = ST_SELECT;
      ST_SELECT:
        if (cancel)
          state_d = (credit_q == '0) ? ST_IDLE : ST_RETURN_CHANGE;
        else if (item_valid && !sel_empty)
          state_d = ST_RECEIVE_MONEY;
      ST_RECEIVE_MONEY:
        if (cancel)
          state_d = ST_RETURN_CHANGE;
        else if (done_money)
          state_d = ST_COMPARE;
        else if (coin_valid) begin
          if (coin_ok && coin_over) state_d = ST_RETURN_CHANGE;
        end else if (tmr_q == '0)
          state_d = ST_RETURN_CHANGE;
      ST_COMPARE:
        state_d = can_buy ? ST_PROCESS : ST_RECEIVE_MONEY;
      ST_PROCESS:
        state_d = continue_buy ? ST_SELECT : ST_RETURN_CHANGE;
      ST_RETURN_CHANGE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so each pulse lines up
  // with the cycle the controller spends in the corresponding state.
  always_comb begin
    credit_d      = credit_q;
    price_d       = price;
    item_d        = item_select;
    change_d      = '0;
    end_d         = 1'b0;
    out_stock_d   = 1'b0;
    reject_d      = 1'b0;
    insuf_d       = 1'b0;
    stock_dec     = 1'b0;
    stock_restock = 1'b0;
    case (state_q)
      ST_IDLE:
        stock_restock = restock_en;
      ST_SELECT:
        if (!cancel && item_valid) begin
          if (sel_empty) begin
            out_stock_d = 1'b1;
          end else begin
            price_d = sel_price;
            item_d  = item_in;
          end
        end
      ST_RECEIVE_MONEY:
        if (!cancel && !done_money && coin_valid) begin
          if (!coin_ok || coin_over) reject_d = 1'b1;
          else                       credit_d = credit_sum[SUM_W-1:0];
        end
      ST_COMPARE:
        insuf_d = !can_buy;
      ST_PROCESS: begin
        credit_d  = credit_q - price;
        stock_dec = 1'b1;
      end
      ST_RETURN_CHANGE:
        credit_d = '0;
      default: ;
    endcase

    if (state_d == ST_IDLE) begin
      price_d = '0;
      item_d  = '0;
    end

    done_d = (state_d == ST_PROCESS);
    if (state_d == ST_RETURN_CHANGE) begin
      end_d    = 1'b1;
      change_d = credit_d;
    end

    if (state_d != ST_RECEIVE_MONEY)
      tmr_d = '0;
    else if (state_q != ST_RECEIVE_MONEY || coin_valid)
      tmr_d = TMR_W'(TIMEOUT - 1);
    else
      tmr_d = tmr_q - TMR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q     <= '0;
      price        <= '0;
      item_select  <= '0;
      tmr_q        <= '0;
      done         <= 1'b0;
      end_trans    <= 1'b0;
      change       <= '0;
      out_stock    <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      price        <= price_d;
      item_select  <= item_d;
      tmr_q        <= tmr_d;
      done         <= done_d;
      end_trans    <= end_d;
      change       <= change_d;
      out_stock    <= out_stock_d;
      coin_reject  <= reject_d;
      insufficient <= insuf_d;
    end
  end

  vend_stock #(
    .N_ITEMS   (N_ITEMS),
    .ITEM_W    (ITEM_W),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK)
  ) u_stock (
    .clk         (clk),
    .reset_n     (reset_n),
    .dec_en      (stock_dec),
    .dec_item    (item_select),
    .restock_en  (stock_restock),
    .restock_item(restock_item),
    .restock_qty (restock_qty),
    .empty       (empty)
  );

endmodule
